// File: rtl/alien_shot_scheduler.sv
// Round-robin arbiter for the single alien projectile, plus the shot lifetime
// sequencer: CPU notify, projectile in flight, then an enforced cooldown.
module alien_shot_scheduler #(
  parameter int NUM_ALIENS = 8,
  parameter int IDX_W      = 3,
  parameter int COOLDOWN   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_ALIENS-1:0] alien_req,
  input  logic [NUM_ALIENS-1:0] alien_alive,
  input  logic                  cpu_ack,
  input  logic                  shot_done,
  output logic                  shoot_flag,
  output logic [IDX_W-1:0]      shoot_idx,
  output logic                  shot_active,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_IN_FLIGHT,
    ST_COOLDOWN
  } state_t;

  localparam logic [15:0] CD_LOAD = 16'(COOLDOWN);

  state_t                  state_reg, state_next;
  logic                    flag_reg, flag_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    active_reg, active_next;
  logic                    busy_reg, busy_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [15:0]             cnt_reg, cnt_next;

  logic [NUM_ALIENS-1:0]   eligible;
  logic [NUM_ALIENS-1:0]   upper;
  logic [IDX_W-1:0]        winner;

  assign eligible = alien_req & alien_alive;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest.
  generate
    for (genvar gi = 0; gi < NUM_ALIENS; gi++) begin : g_upper
      assign upper[gi] = eligible[gi] && (IDX_W'(gi) >= ptr_reg);
    end
  endgenerate

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_ALIENS-1:0] v);
    first_set = '0;
    for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDX_W'(i);
    end
  endfunction

  assign winner = (|upper) ? first_set(upper) : first_set(eligible);

  always_comb begin
    state_next  = state_reg;
    flag_next   = flag_reg;
    idx_next    = idx_reg;
    active_next = active_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable && (|eligible)) begin
          state_next = ST_WAIT_ACK;
          flag_next  = 1'b1;
          idx_next   = winner;
          ptr_next   = (winner == IDX_W'(NUM_ALIENS - 1)) ? '0 : winner + IDX_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (cpu_ack) begin
          flag_next   = 1'b0;
          active_next = 1'b1;
          state_next  = ST_IN_FLIGHT;
        end
      end
      ST_IN_FLIGHT: begin
        if (shot_done) begin
          active_next = 1'b0;
          if (COOLDOWN == 0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next   = CD_LOAD - 16'd1;
            state_next = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        // Counter parks at zero on the exit cycle, so it never wraps.
        if (cnt_reg == 16'd0) state_next = ST_IDLE;
        else                  cnt_next   = cnt_reg - 16'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_next = (state_next != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      flag_reg   <= 1'b0;
      idx_reg    <= '0;
      active_reg <= 1'b0;
      busy_reg   <= 1'b0;
      ptr_reg    <= '0;
      cnt_reg    <= 16'd0;
    end else begin
      state_reg  <= state_next;
      flag_reg   <= flag_next;
      idx_reg    <= idx_next;
      active_reg <= active_next;
      busy_reg   <= busy_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign shoot_flag  = flag_reg;
  assign shoot_idx   = idx_reg;
  assign shot_active = active_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Bench for alien_shot_scheduler: directed scenarios with literal checks, then
// randomized traffic compared every cycle against a behavioural model.
module tb_alien_shot_scheduler;

  localparam int N  = 8;
  localparam int CD = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         cpu_ack = 1'b0;
  logic         shot_done = 1'b0;
  logic [N-1:0] alien_req = '0;
  logic [N-1:0] alien_alive = '0;
  logic         shoot_flag, shot_active, busy;
  logic [2:0]   shoot_idx;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  alien_shot_scheduler #(.NUM_ALIENS(N), .IDX_W(3), .COOLDOWN(CD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .alien_req(alien_req), .alien_alive(alien_alive),
    .cpu_ack(cpu_ack), .shot_done(shot_done),
    .shoot_flag(shoot_flag), .shoot_idx(shoot_idx),
    .shot_active(shot_active), .busy(busy)
  );

  // Model: shot phase is implied by which of flag/active/busy are set;
  // cool counts remaining busy cycles after the projectile lands.
  logic       m_flag = 1'b0, m_active = 1'b0, m_busy = 1'b0;
  logic [2:0] m_idx = '0;
  int         m_ptr = 0, m_cool = 0;

  always @(posedge clk) begin : model
    logic f, a, b;
    logic [2:0] ix;
    int p, c, j;
    logic [N-1:0] el;
    f = m_flag; a = m_active; b = m_busy; ix = m_idx; p = m_ptr; c = m_cool;
    el = alien_req & alien_alive;
    if (reset) begin
      f = 0; a = 0; b = 0; ix = 0; p = 0; c = 0;
    end else if (f) begin
      if (cpu_ack) begin f = 0; a = 1; end
    end else if (a) begin
      if (shot_done) begin
        a = 0;
        if (CD == 0) b = 0;
        else c = CD;
      end
    end else if (b) begin
      c = c - 1;
      if (c == 0) b = 0;
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        j = (p + k) % N;
        if (el[j]) begin
          ix = 3'(j); f = 1; b = 1; p = (j + 1) % N;
          break;
        end
      end
    end
    m_flag <= f; m_active <= a; m_busy <= b; m_idx <= ix; m_ptr <= p; m_cool <= c;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_flag", 32'(shoot_flag), 32'(m_flag));
      chk("model_idx", 32'(shoot_idx), 32'(m_idx));
      chk("model_active", 32'(shot_active), 32'(m_active));
      chk("model_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ack, land, and sit out the cooldown (with a stray ack inside it);
  // returns in IDLE, one edge before the next possible grant.
  task automatic run_shot;
    cpu_ack = 1; wait_cyc(1); cpu_ack = 0;
    chk("ack_active", 32'(shot_active), 32'd1);
    chk("ack_flag", 32'(shoot_flag), 32'd0);
    shot_done = 1; wait_cyc(1); shot_done = 0;
    chk("done_active", 32'(shot_active), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    wait_cyc(1); cpu_ack = 1; wait_cyc(1); cpu_ack = 0;
    wait_cyc(2);
    chk("cool_busy_hi", 32'(busy), 32'd1);
    wait_cyc(1);
    chk("cool_busy_lo", 32'(busy), 32'd0);
    chk("cool_flag_lo", 32'(shoot_flag), 32'd0);
  endtask

  initial begin
    reset = 1; wait_cyc(2);
    chk_en = 1;
    reset = 0; alien_req = 8'h00;
    wait_cyc(20);
    chk("idle_flag", 32'(shoot_flag), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_idx", 32'(shoot_idx), 32'd0);

    enable = 1; alien_alive = 8'hFF; alien_req = 8'h24;
    wait_cyc(1);
    chk("rr_flag0", 32'(shoot_flag), 32'd1);
    chk("rr_idx0", 32'(shoot_idx), 32'd2);
    run_shot();
    wait_cyc(1);
    chk("rr_flag1", 32'(shoot_flag), 32'd1);
    chk("rr_idx1", 32'(shoot_idx), 32'd5);
    run_shot();
    wait_cyc(1);
    chk("rr_idx2", 32'(shoot_idx), 32'd2);
    alien_req = 8'h00;
    run_shot();

    alien_req = 8'h80; alien_alive = 8'h7F;
    wait_cyc(3);
    chk("dead_noflag", 32'(shoot_flag), 32'd0);
    alien_alive = 8'hFF;
    wait_cyc(1);
    chk("alive_flag", 32'(shoot_flag), 32'd1);
    chk("alive_idx", 32'(shoot_idx), 32'd7);
    alien_req = 8'h81;
    run_shot();
    wait_cyc(1);
    chk("wrap_idx", 32'(shoot_idx), 32'd0);

    enable = 0; alien_req = 8'h00;
    wait_cyc(3);
    chk("hold_flag", 32'(shoot_flag), 32'd1);
    cpu_ack = 1; wait_cyc(1); cpu_ack = 0;
    chk("hold_active", 32'(shot_active), 32'd1);
    reset = 1; wait_cyc(1);
    chk("rst_flag", 32'(shoot_flag), 32'd0);
    chk("rst_active", 32'(shot_active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(shoot_idx), 32'd0);
    reset = 0; enable = 1; alien_req = 8'hFF;
    wait_cyc(1);
    chk("rst_grant_idx", 32'(shoot_idx), 32'd0);

    alien_req = 8'h00;
    shot_done = 1; wait_cyc(1); shot_done = 0;
    chk("early_done_flag", 32'(shoot_flag), 32'd1);
    chk("early_done_active", 32'(shot_active), 32'd0);
    run_shot();
    cpu_ack = 1; wait_cyc(1); cpu_ack = 0;
    chk("idle_ack_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 249) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) alien_req = 8'($urandom);
      if ($urandom_range(0, 7) == 0) alien_alive = 8'($urandom | $urandom);
      cpu_ack     = ($urandom_range(0, 3) == 0);
      shot_done   = ($urandom_range(0, 3) == 0);
      wait_cyc(1);
    end
    reset = 0; cpu_ack = 0; shot_done = 0;
    wait_cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_shot_scheduler.md
Name: alien_shot_scheduler

Overview:
- Arbitrates fire requests from NUM_ALIENS alien sprites for the single alien projectile available in the game.
- Fair round-robin grant, then sequences one shot's lifetime: CPU notify, projectile in flight, cooldown.
- shoot_flag drives the 1-bit alien-shoot PIO input that the Nios II CPU polls; shoot_idx tells the CPU which alien fires.
- CPU acknowledges through a PIO output bit (cpu_ack); the projectile-collision logic reports shot completion.

Parameters:
- NUM_ALIENS, 8, number of requesters (2..32).
- IDX_W, 3, width of shoot_idx; must be >= clog2(NUM_ALIENS).
- COOLDOWN, 1000, idle clock cycles enforced after each shot completes before the next grant (0..2^16-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  game-running gate; 0 blocks new grants only.
- alien_req  input  NUM_ALIENS  level fire requests, one per alien.
- alien_alive  input  NUM_ALIENS  alive mask; a request counts only if req&alive.
- cpu_ack  input  1  single-cycle pulse: CPU has read and launched the shot.
- shot_done  input  1  single-cycle pulse: projectile hit something or left the screen.
- shoot_flag  output  1  to PIO in_port; high while a granted shot awaits CPU ack.
- shoot_idx  output  IDX_W  index of the granted alien; stable from grant until the next grant.
- shot_active  output  1  projectile in flight.
- busy  output  1  high in any state except IDLE.

Behaviour:
- All outputs registered. Reset (sync, high) forces: state=IDLE, shoot_flag=0, shoot_idx=0, shot_active=0, busy=0, cooldown counter=0, round-robin pointer=0 (alien 0 highest priority). Applies mid-operation too; pending request bits are not remembered.
- FSM states: IDLE, WAIT_ACK, IN_FLIGHT, COOLDOWN.
- IDLE: if enable=1 and eligible=(alien_req&alien_alive)!=0, grant the first set bit searching upward from the pointer with wrap. Next edge: shoot_idx<=winner, shoot_flag<=1, busy<=1, pointer<=(winner+1) mod NUM_ALIENS, state<=WAIT_ACK. Latency from request to shoot_flag is one cycle. If nothing is eligible or enable=0, stay in IDLE.
- WAIT_ACK: hold shoot_flag=1. On cpu_ack: shoot_flag<=0, shot_active<=1, state<=IN_FLIGHT. Changes to req or alive in this state are ignored; the grant is not revoked. shot_done is ignored. enable=0 does not cancel the shot.
- IN_FLIGHT: on shot_done, shot_active<=0.
  - If COOLDOWN=0: state<=IDLE, busy<=0.
  - Otherwise: counter<=COOLDOWN-1, state<=COOLDOWN.
  - cpu_ack is ignored in this state.
- COOLDOWN: decrement the counter each cycle. When counter==0, state<=IDLE, busy<=0. Total gap from shot_done to earliest next shoot_flag rise is COOLDOWN+2 cycles, or 2 cycles when COOLDOWN=0. The counter is 16 bits and never wraps below 0.
- Acks and shot_done pulses arriving in IDLE or COOLDOWN are ignored; they are not queued.
- Pointer wrap: after granting NUM_ALIENS-1, the pointer returns to 0.
- A requester that stays continuously asserted cannot be granted twice while another eligible requester waits.

Test Plan:
- Reset, then alien_req=8'h00: after 20 cycles, shoot_flag=0, busy=0, shoot_idx=0.
- alien_req=8'h24, alive=8'hFF, enable=1: shoot_flag=1 and shoot_idx=2 one cycle later. After cpu_ack, shot_done, and cooldown, the next grant is shoot_idx=5 with req still 8'h24. Round-robin continues 2,5,2.
- alien_req=8'h80 with alive=8'h7F: no grant. Set alive=8'hFF: next cycle, shoot_flag=1 and shoot_idx=7. Following grant with req=8'h81 goes to idx 0 (wrap).
- COOLDOWN=5: shot_done at cycle T gives busy=0 at T+6 and the next shoot_flag rise at T+7. Assert a cpu_ack pulse during COOLDOWN: no state change.
- In WAIT_ACK, drop enable and alien_req to 0: shoot_flag stays 1. cpu_ack then gives shot_active=1. Assert reset during IN_FLIGHT: next cycle all outputs are 0, and the next grant with req=8'hFF is idx 0.
- shot_done pulse while in WAIT_ACK: ignored, state unchanged. A later shot_done after cpu_ack completes the shot normally.
